// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty/level flags and error reporting.
// Optional almost_empty output is enabled by defining FIFO_ALMOST_EMPTY_EN.
module fifo_read_ctrl #(
    parameter int SIZE      = 4,
    parameter int AE_THRESH = 2
) (
    input  logic            dest_clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [SIZE-1:0] wr_ptr_synch,
    output logic [SIZE-2:0] rd_addr,
    output logic [SIZE-1:0] rd_ptr,
    output logic            rd_valid,
    output logic            empty,
    output logic [SIZE-1:0] level,
    output logic            underflow,
`ifdef FIFO_ALMOST_EMPTY_EN
    output logic            almost_empty,
`endif
    output logic            ptr_err
);

    // Full-FIFO occupancy; anything above it means the pointers disagree.
    localparam logic [SIZE-1:0] L_DEPTH = {1'b1, {(SIZE-1){1'b0}}};

    logic [SIZE-1:0] r_rd_ptr;
    logic            r_rd_valid;
    logic            r_empty;
    logic [SIZE-1:0] r_level;
    logic            r_underflow;
    logic            r_ptr_err;

    logic            w_rd_accept;
    logic [SIZE-1:0] w_rd_ptr_next;
    logic [SIZE-1:0] w_level_next;

    assign w_rd_accept   = rd_en & ~r_empty;
    assign w_rd_ptr_next = r_rd_ptr + {{(SIZE-1){1'b0}}, w_rd_accept};
    // Modular subtraction keeps the level correct across pointer wrap.
    assign w_level_next  = wr_ptr_synch - w_rd_ptr_next;

    always_ff @(posedge dest_clk) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_empty     <= 1'b1;
            r_level     <= '0;
            r_underflow <= 1'b0;
            r_ptr_err   <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_next;
            r_rd_valid  <= w_rd_accept;
            r_empty     <= (w_rd_ptr_next == wr_ptr_synch);
            r_level     <= w_level_next;
            r_underflow <= rd_en & r_empty;
            if (w_level_next > L_DEPTH)
                r_ptr_err <= 1'b1;
        end
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    localparam logic [SIZE:0] L_AE_THRESH = (SIZE+1)'(AE_THRESH);

    logic r_almost_empty;

    always_ff @(posedge dest_clk) begin
        if (!rst_n)
            r_almost_empty <= 1'b1;
        else
            r_almost_empty <= ({1'b0, w_level_next} <= L_AE_THRESH);
    end

    assign almost_empty = r_almost_empty;
`endif

    assign rd_addr   = r_rd_ptr[SIZE-2:0];
    assign rd_ptr    = r_rd_ptr;
    assign rd_valid  = r_rd_valid;
    assign empty     = r_empty;
    assign level     = r_level;
    assign underflow = r_underflow;
    assign ptr_err   = r_ptr_err;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl at SIZE=4, AE_THRESH=2; almost_empty checks
// are included when FIFO_ALMOST_EMPTY_EN is defined.
module tb_fifo_read_ctrl;

    localparam int SIZE = 4;

    logic            dest_clk = 1'b0;
    logic            rst_n;
    logic            rd_en;
    logic [SIZE-1:0] wr_ptr_synch;
    logic [SIZE-2:0] rd_addr;
    logic [SIZE-1:0] rd_ptr;
    logic            rd_valid;
    logic            empty;
    logic [SIZE-1:0] level;
    logic            underflow;
    logic            ptr_err;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic            almost_empty;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_read_ctrl #(.SIZE(SIZE), .AE_THRESH(2)) dut (
        .dest_clk     (dest_clk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .wr_ptr_synch (wr_ptr_synch),
        .rd_addr      (rd_addr),
        .rd_ptr       (rd_ptr),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .level        (level),
        .underflow    (underflow),
`ifdef FIFO_ALMOST_EMPTY_EN
        .almost_empty (almost_empty),
`endif
        .ptr_err      (ptr_err)
    );

    always #5 dest_clk = ~dest_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge dest_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rd_ptr"},    32'(rd_ptr),    0);
        chk({tag, " rd_addr"},   32'(rd_addr),   0);
        chk({tag, " rd_valid"},  32'(rd_valid),  0);
        chk({tag, " empty"},     32'(empty),     1);
        chk({tag, " level"},     32'(level),     0);
        chk({tag, " underflow"}, 32'(underflow), 0);
        chk({tag, " ptr_err"},   32'(ptr_err),   0);
`ifdef FIFO_ALMOST_EMPTY_EN
        chk({tag, " almost_empty"}, 32'(almost_empty), 1);
`endif
    endtask

    int exp_ptr [3];
    int exp_addr[3];
    int exp_lvl [3];

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; wr_ptr_synch = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Reads on an empty FIFO are rejected and flagged
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("uf%0d underflow", i), 32'(underflow), 1);
            chk($sformatf("uf%0d rd_ptr", i),    32'(rd_ptr),    0);
            chk($sformatf("uf%0d rd_valid", i),  32'(rd_valid),  0);
            chk($sformatf("uf%0d empty", i),     32'(empty),     1);
        end
        rd_en = 1'b0;
        tick();
        chk("uf_end underflow", 32'(underflow), 0);

        // Three entries written, streamed out back-to-back
        wr_ptr_synch = 4'd3;
        tick();
        chk("s3 empty", 32'(empty), 0);
        chk("s3 level", 32'(level), 3);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s3 rd_addr%0d", i), 32'(rd_addr), 32'(i));
            tick();
            chk($sformatf("s3 rd_valid%0d", i),  32'(rd_valid),  1);
            chk($sformatf("s3 rd_ptr%0d", i),    32'(rd_ptr),    32'(i + 1));
            chk($sformatf("s3 level%0d", i),     32'(level),     32'(2 - i));
            chk($sformatf("s3 underflow%0d", i), 32'(underflow), 0);
        end
        chk("s3 empty_end", 32'(empty), 1);
        tick();
        chk("s3 underflow_after", 32'(underflow), 1);
        chk("s3 rd_valid_after",  32'(rd_valid),  0);
        chk("s3 rd_ptr_after",    32'(rd_ptr),    3);
        rd_en = 1'b0;

        // Advance rd_ptr to 14, then read across the wrap point
        wr_ptr_synch = 4'd14;
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_en = 1'b0;
        chk("pre_wrap rd_ptr", 32'(rd_ptr), 14);
        chk("pre_wrap empty",  32'(empty),  1);
        wr_ptr_synch = 4'd1;
        tick();
        chk("wrap level", 32'(level), 3);
        chk("wrap empty", 32'(empty), 0);
        exp_ptr  = '{15, 0, 1};
        exp_addr = '{6, 7, 0};
        exp_lvl  = '{2, 1, 0};
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap rd_addr%0d", i), 32'(rd_addr), 32'(exp_addr[i]));
            tick();
            chk($sformatf("wrap rd_ptr%0d", i), 32'(rd_ptr), 32'(exp_ptr[i]));
            chk($sformatf("wrap level%0d", i),  32'(level),  32'(exp_lvl[i]));
        end
        rd_en = 1'b0;
        chk("wrap rd_addr_end", 32'(rd_addr), 1);
        chk("wrap empty_end",   32'(empty),   1);

        // Move rd_ptr to 4, then read while the write pointer moves the same cycle
        wr_ptr_synch = 4'd4;
        tick();
        rd_en = 1'b1;
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("same rd_ptr4", 32'(rd_ptr), 4);
        wr_ptr_synch = 4'd5;
        tick();
        chk("same empty_pre", 32'(empty), 0);
        chk("same level_pre", 32'(level), 1);
        rd_en = 1'b1;
        wr_ptr_synch = 4'd6;
        tick();
        chk("same rd_ptr5",  32'(rd_ptr), 5);
        chk("same empty_ne", 32'(empty),  0);
        chk("same level1",   32'(level),  1);
        tick();
        rd_en = 1'b0;
        chk("same rd_ptr6", 32'(rd_ptr), 6);
        chk("same empty",   32'(empty),  1);
        chk("same level0",  32'(level),  0);

        // Pointer inconsistency: level 8 is legal, level 12 is not
        rst_n = 1'b0;
        wr_ptr_synch = 4'd0;
        tick();
        rst_n = 1'b1;
        wr_ptr_synch = 4'd8;
        tick();
        chk("perr level8",   32'(level),   8);
        chk("perr ok_at_8",  32'(ptr_err), 0);
        wr_ptr_synch = 4'd12;
        tick();
        chk("perr set",      32'(ptr_err), 1);
        chk("perr level12",  32'(level),   12);
        wr_ptr_synch = 4'd2;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("perr sticky",   32'(ptr_err), 1);
        chk("perr rd_ptr",   32'(rd_ptr),  1);
        chk("perr level1",   32'(level),   1);
        tick();
        chk("perr sticky2",  32'(ptr_err), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("perr cleared",  32'(ptr_err), 0);

        // Almost-empty threshold, then reset in the middle of a read burst
        wr_ptr_synch = 4'd4;
        tick();
        chk("ae level4", 32'(level), 4);
`ifdef FIFO_ALMOST_EMPTY_EN
        chk("ae lvl4", 32'(almost_empty), 0);
`endif
        rd_en = 1'b1;
        tick();
        chk("ae level3", 32'(level), 3);
`ifdef FIFO_ALMOST_EMPTY_EN
        chk("ae lvl3", 32'(almost_empty), 0);
`endif
        tick();
        chk("ae level2", 32'(level), 2);
`ifdef FIFO_ALMOST_EMPTY_EN
        chk("ae lvl2", 32'(almost_empty), 1);
`endif
        chk("mid rd_valid", 32'(rd_valid), 1);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        rd_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
